can_tx_mailbox_arbiter: RTL

- Schedules CAN transmit requests from N host mailboxes onto the single shared CAN transmit engine.
- Turns each level-held host request into a one-shot queue entry, then picks the pending mailbox with the highest bus priority (lowest identifier).
- Sequences the engine through a start/done handshake and reports per-mailbox success or failure as single-cycle pulses.
- Sits between the host register file and the bit-level TX core.

---
 rtl/can_pkg.sv | 19 +
 rtl/can_prio_select.sv | 40 ++++
 rtl/can_tx_mailbox_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions for the transmit mailbox arbiter.
// Contents:
//   arb_state_e  - arbiter FSM state encoding (IDLE, SELECT, START, WAIT, RETIRE)
//   CAN_STD_ID_W - standard (11-bit) identifier width
//   CAN_EXT_ID_W - extended (29-bit) identifier width
package can_pkg;

  localparam int CAN_STD_ID_W = 11;
  localparam int CAN_EXT_ID_W = 29;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RETIRE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/can_prio_select.sv
// Combinational priority finder: returns the candidate mailbox with the
// lowest identifier (unsigned compare); on equal identifiers the lower
// index wins.
// Ports:
//   cand      - candidate mailbox vector
//   ids       - packed identifiers, mailbox i at [i*ID_W +: ID_W]
//   win_idx   - index of the winning mailbox (0 when none)
//   win_valid - at least one candidate present
module can_prio_select
  import can_pkg::*;
#(
  parameter int N_MBOX = 4,
  parameter int ID_W   = CAN_STD_ID_W,
  parameter int SEL_W  = $clog2(N_MBOX)
) (
  input  logic [N_MBOX-1:0]      cand,
  input  logic [N_MBOX*ID_W-1:0] ids,
  output logic [SEL_W-1:0]       win_idx,
  output logic                   win_valid
);

  logic [ID_W-1:0] best_id_s;

  // Linear scan from index 0; strict less-than keeps the lower index on ties.
  always_comb begin
    win_idx   = {SEL_W{1'b0}};
    win_valid = 1'b0;
    best_id_s = {ID_W{1'b0}};
    for (int i = 0; i < N_MBOX; i++) begin
      if (cand[i] && (!win_valid || (ids[i*ID_W +: ID_W] < best_id_s))) begin
        win_idx   = SEL_W'(i);
        win_valid = 1'b1;
        best_id_s = ids[i*ID_W +: ID_W];
      end else begin
        win_valid = win_valid;
      end
    end
  end

endmodule

// File: rtl/can_tx_mailbox_arbiter.sv
// Schedules transmit requests from N_MBOX host mailboxes onto one CAN TX
// engine: captures request edges into a pending vector, picks the lowest-ID
// pending mailbox, runs the start/done handshake and reports the outcome.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   tx_req, mbox_id      - host request levels and per-mailbox identifiers
//   abort                - per-mailbox cancel
//   core_ready/start/sel - engine handshake (sel stable from start to retire)
//   core_done/arb_lost/error - engine result pulses
//   tx_pending, tx_ok, tx_fail - per-mailbox status and result pulses
//   busy                 - FSM not idle
module can_tx_mailbox_arbiter
  import can_pkg::*;
#(
  parameter  int N_MBOX        = 4,
  parameter  int ID_W          = CAN_STD_ID_W,
  parameter  int ERR_RETRY_MAX = 3,
  localparam int SEL_W         = $clog2(N_MBOX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_MBOX-1:0]      tx_req,
  input  logic [N_MBOX*ID_W-1:0] mbox_id,
  input  logic [N_MBOX-1:0]      abort,
  input  logic                   core_ready,
  output logic                   core_start,
  output logic [SEL_W-1:0]       core_sel,
  input  logic                   core_done,
  input  logic                   core_arb_lost,
  input  logic                   core_error,
  output logic [N_MBOX-1:0]      tx_pending,
  output logic [N_MBOX-1:0]      tx_ok,
  output logic [N_MBOX-1:0]      tx_fail,
  output logic                   busy
);

  arb_state_e        state_r;
  logic [N_MBOX-1:0] req_q_r, pending_r, tx_ok_r, tx_fail_r;
  logic              edge_vld_r;   // req_q_r holds a real sample (not reset value)
  logic [SEL_W-1:0]  winner_r;
  logic              core_start_r, busy_r;
  logic [3:0]        err_cnt_r;
  logic              retry_err_r;  // last retire kept the winner pending after an error
  logic              abort_lat_r;  // abort seen on the in-flight mailbox

  logic [N_MBOX-1:0] rise_s, win_oh_s, inflight_s, abort_clr_s, cand_s, ret_clr_s;
  logic [SEL_W-1:0]  sel_idx_s;
  logic              sel_vld_s;
  logic              abort_hit_s, last_try_s, ret_ok_s, ret_fail_s, ret_retry_s;

  // Request edges, abort filtering and selection candidates.
  always_comb begin
    win_oh_s = {{(N_MBOX-1){1'b0}}, 1'b1} << winner_r;
    // Without a valid previous sample a held-high request must not look like an edge.
    rise_s   = tx_req & ~req_q_r & {N_MBOX{edge_vld_r}};
    if ((state_r == ST_START) || (state_r == ST_WAIT)) begin
      inflight_s = win_oh_s;
    end else begin
      inflight_s = {N_MBOX{1'b0}};
    end
    abort_clr_s = abort & pending_r & ~inflight_s;
    // A mailbox aborted during SELECT must not be chosen.
    cand_s      = pending_r & ~abort_clr_s;
  end

  can_prio_select #(
    .N_MBOX (N_MBOX),
    .ID_W   (ID_W),
    .SEL_W  (SEL_W)
  ) u_prio (
    .cand      (cand_s),
    .ids       (mbox_id),
    .win_idx   (sel_idx_s),
    .win_valid (sel_vld_s)
  );

  // Frame outcome decode in WAIT; priority done > error > arb_lost.
  always_comb begin
    abort_hit_s = abort_lat_r | (|(abort & win_oh_s));
    last_try_s  = ((err_cnt_r + 4'd1) == 4'(ERR_RETRY_MAX));
    ret_ok_s    = 1'b0;
    ret_fail_s  = 1'b0;
    ret_retry_s = 1'b0;
    if (state_r == ST_WAIT) begin
      if (core_done) begin
        ret_ok_s = 1'b1;
      end else if (core_error) begin
        if (abort_hit_s || last_try_s) begin
          ret_fail_s = 1'b1;
        end else begin
          ret_retry_s = 1'b1;
        end
      end else begin
        ret_ok_s = 1'b0;
      end
    end else begin
      ret_ok_s = 1'b0;
    end
    if (ret_ok_s || ret_fail_s) begin
      ret_clr_s = win_oh_s;
    end else begin
      ret_clr_s = {N_MBOX{1'b0}};
    end
  end

  // Edge registers, pending vector and result pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q_r    <= {N_MBOX{1'b0}};
      edge_vld_r <= 1'b0;
      pending_r  <= {N_MBOX{1'b0}};
      tx_ok_r    <= {N_MBOX{1'b0}};
      tx_fail_r  <= {N_MBOX{1'b0}};
    end else begin
      req_q_r    <= tx_req;
      edge_vld_r <= 1'b1;
      pending_r  <= (pending_r & ~abort_clr_s & ~ret_clr_s) | (rise_s & ~pending_r);
      tx_ok_r    <= ret_ok_s ? win_oh_s : {N_MBOX{1'b0}};
      tx_fail_r  <= abort_clr_s | (ret_fail_s ? win_oh_s : {N_MBOX{1'b0}});
    end
  end

  // Arbiter FSM with registered handshake outputs and retry bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      winner_r     <= {SEL_W{1'b0}};
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      err_cnt_r    <= 4'd0;
      retry_err_r  <= 1'b0;
      abort_lat_r  <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if ((|pending_r) && core_ready) begin
            state_r <= ST_SELECT;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (sel_vld_s) begin
            winner_r     <= sel_idx_s;
            core_start_r <= 1'b1;
            abort_lat_r  <= 1'b0;
            state_r      <= ST_START;
            if (!(retry_err_r && (sel_idx_s == winner_r))) begin
              err_cnt_r <= 4'd0;
            end else begin
              err_cnt_r <= err_cnt_r;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_START: begin
          abort_lat_r <= abort_hit_s;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          abort_lat_r <= abort_hit_s;
          if (ret_ok_s || ret_fail_s) begin
            retry_err_r <= 1'b0;
            state_r     <= ST_RETIRE;
          end else if (ret_retry_s) begin
            retry_err_r <= 1'b1;
            err_cnt_r   <= err_cnt_r + 4'd1;
            state_r     <= ST_RETIRE;
          end else if (core_arb_lost) begin
            state_r     <= ST_RETIRE;
          end else begin
            state_r     <= ST_WAIT;
          end
        end
        ST_RETIRE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign core_start = core_start_r;
  assign core_sel   = winner_r;
  assign tx_pending = pending_r;
  assign tx_ok      = tx_ok_r;
  assign tx_fail    = tx_fail_r;
  assign busy       = busy_r;

endmodule
